bram_slice_reader: RTL and testbench

BRAM_SLICE_READER -- requirements
Module: bram_slice_reader

---
 rtl/bram_slice_reader_if.sv | 34 +++
 rtl/bram_slice_reader.sv | 125 ++++++++++++
 tb/tb_bram_slice_reader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/bram_slice_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_slice_reader_if
// Brief    : Request, RAM-read and word-output signals of bram_slice_reader.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_slice_reader_if #(
  parameter int ADDR_W  = 10,
  parameter int PES     = 16,
  parameter int MAX_LEN = 32
);
  logic               start;
  logic [ADDR_W-1:0]  base_addr;
  logic [4:0]         word_len;
  logic [ADDR_W-1:0]  addr;
  logic [PES-1:0]     dout;
  logic               out_valid;
  logic               out_ready;
  logic [MAX_LEN-1:0] out_data;
  logic [3:0]         out_pe;
  logic               busy;
  logic               done;

  modport slave (
    input  start, base_addr, word_len, dout, out_ready,
    output addr, out_valid, out_data, out_pe, busy, done
  );

  modport master (
    output start, base_addr, word_len, dout, out_ready,
    input  addr, out_valid, out_data, out_pe, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/bram_slice_reader.sv
`default_nettype none
// ============================================================================
// Module   : bram_slice_reader
// Brief    : Reads len bit-slices from a RAM and emits one transposed word per PE.
// Revision : 1.0 - initial release
// ============================================================================
module bram_slice_reader #(
  parameter int ADDR_W  = 10,
  parameter int PES     = 16,
  parameter int MAX_LEN = 32
) (
  input  wire logic             clk,
  input  wire logic             reset,
  bram_slice_reader_if.slave    bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_LAST  = 2'd2;
  localparam logic [1:0] c_EMIT  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [5:0]          r_len;
  logic [4:0]          r_k;
  logic                r_cap1;
  logic                r_cap2;
  logic [4:0]          r_idx2;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_pe;
  logic                r_done;
  logic [MAX_LEN-1:0]  r_buf [PES];

  logic                w_start;
  logic                w_fetch_end;
  logic                w_accept;
  logic                w_last_pe;
  logic                w_busy;
  logic                w_out_valid;
  logic [MAX_LEN-1:0]  w_out_data;

  assign w_start     = (r_state == c_IDLE) && bus.start;
  assign w_fetch_end = (r_state == c_FETCH) && ({1'b0, r_k} == (r_len - 6'd1));
  assign w_accept    = (r_state == c_EMIT) && bus.out_ready;
  assign w_last_pe   = (r_pe == 4'(PES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_start) w_next = c_FETCH;
      c_FETCH: if (w_fetch_end) w_next = c_LAST;
      c_LAST:  w_next = c_EMIT;
      c_EMIT:  if (w_accept && w_last_pe) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != c_IDLE);
    w_out_valid = (r_state == c_EMIT);
    w_out_data  = '0;
    if (w_out_valid) w_out_data = r_buf[r_pe];
  end

  // cap1/cap2 track each issued slice through the one-cycle RAM read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len  <= '0;
      r_k    <= '0;
      r_cap1 <= 1'b0;
      r_cap2 <= 1'b0;
      r_idx2 <= '0;
      r_addr <= '0;
      r_pe   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_accept && w_last_pe;
      r_cap2 <= r_cap1;
      r_idx2 <= r_k;
      r_cap1 <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_len  <= (bus.word_len == 5'd0) ? 6'd32 : {1'b0, bus.word_len};
            r_addr <= bus.base_addr;
            r_k    <= '0;
            r_cap1 <= 1'b1;
          end
        end
        c_FETCH: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (!w_fetch_end) begin
            r_k    <= r_k + 5'd1;
            r_cap1 <= 1'b1;
          end
        end
        c_LAST: r_pe <= '0;
        c_EMIT: if (w_accept) r_pe <= r_pe + 4'd1;
        default: ;
      endcase
    end
  end

  // Cleared on every start, so no reset is needed for the transpose buffer
  always_ff @(posedge clk) begin
    for (int i = 0; i < PES; i++) begin
      if (w_start)     r_buf[i] <= '0;
      else if (r_cap2) r_buf[i][r_idx2] <= bus.dout[i];
    end
  end

  assign bus.addr      = r_addr;
  assign bus.out_pe    = r_pe;
  assign bus.done      = r_done;
  assign bus.busy      = w_busy;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;

endmodule
`default_nettype wire

// File: tb/tb_bram_slice_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_slice_reader
// Brief    : Directed and randomized checks of bram_slice_reader against a word model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_slice_reader;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  logic [15:0] mem [1024];
  logic [31:0] exp_w [16];

  bram_slice_reader_if #(.ADDR_W(10), .PES(16), .MAX_LEN(32)) bus ();

  bram_slice_reader #(.ADDR_W(10), .PES(16), .MAX_LEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM: data appears the cycle after the address is sampled
  always @(posedge clk) bus.dout <= mem[bus.addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int base, input int len, input int pe);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < len; k++) w[k] = mem[(base + k) % 1024][pe];
    return w;
  endfunction

  task automatic load_model(input int base, input int wl);
    int len;
    len = (wl == 0) ? 32 : wl;
    for (int i = 0; i < 16; i++) exp_w[i] = ref_word(base, len, i);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_addr"},  bus.addr, 0);
    chk({tag, "_pe"},    bus.out_pe, 0);
    chk({tag, "_data"},  bus.out_data, 0);
  endtask

  // Called at #1 after an edge; returns at #1 after the edge where out_valid first rises
  task automatic start_run(input int base, input int wl, input bit poke);
    int len;
    len = (wl == 0) ? 32 : wl;
    bus.start     = 1'b1;
    bus.base_addr = 10'(base);
    bus.word_len  = 5'(wl);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_valid", bus.out_valid, 0);
    chk("addr_first", bus.addr, base);
    for (int c = 1; c <= len + 1; c++) begin
      if (poke && c == 1) begin
        bus.start     = 1'b1;
        bus.base_addr = 10'(base + 100);
        bus.word_len  = 5'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (c <= len - 1) chk("addr_seq", bus.addr, (base + c) % 1024);
      chk("valid_timing", bus.out_valid, (c == len + 1) ? 1 : 0);
      chk("run_busy", bus.busy, 1);
    end
    bus.start = 1'b0;
  endtask

  task automatic collect(input bit stall, input int nwords);
    int  pe;
    int  guard;
    bit  rdy;
    pe = 0;
    guard = 0;
    while (pe < nwords && guard < 2000) begin
      chk("emit_valid", bus.out_valid, 1);
      chk("emit_pe", bus.out_pe, pe);
      chk("emit_data", bus.out_data, exp_w[pe]);
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.out_ready = rdy;
      @(posedge clk); #1;
      if (rdy) pe++;
      guard++;
    end
    chk("collect_bound", guard < 2000, 1);
    if (nwords == 16) begin
      chk("done_pulse", bus.done, 1);
      chk("done_valid", bus.out_valid, 0);
      chk("done_busy", bus.busy, 0);
      chk("done_data", bus.out_data, 0);
    end
  endtask

  task automatic idle_cycles(input int n);
    logic [9:0] hold;
    hold = bus.addr;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      chk("idle_done", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
      chk("idle_addr_hold", bus.addr, hold);
    end
  endtask

  initial begin
    int base;
    int wl;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.word_len  = '0;
    bus.out_ready = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    #1;
    check_reset_vals("rst_init");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_released");

    // Alternating all-ones / all-zeros slices give 4'b0101 for every PE
    mem[0] = 16'hFFFF; mem[1] = 16'h0000; mem[2] = 16'hFFFF; mem[3] = 16'h0000;
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h5;
    start_run(0, 4, 1'b0);
    collect(1'b0, 16);
    idle_cycles(3);

    // Address wrap across the top of the RAM
    mem[1022] = 16'($urandom); mem[1023] = 16'($urandom); mem[0] = 16'($urandom);
    load_model(1022, 3);
    start_run(1022, 3, 1'b0);
    collect(1'b1, 16);
    idle_cycles(2);

    // word_len=0 means 32 slices; next run is started in the done cycle
    for (int k = 0; k < 32; k++) mem[200 + k] = 16'(1 << (k % 16));
    for (int i = 0; i < 16; i++) exp_w[i] = (32'h1 << i) | (32'h1 << (i + 16));
    for (int a = 500; a < 507; a++) mem[a] = 16'($urandom);
    start_run(200, 0, 1'b0);
    collect(1'b0, 16);
    load_model(500, 7);
    start_run(500, 7, 1'b0);
    collect(1'b1, 16);
    idle_cycles(1);

    for (int r = 0; r < 5; r++) begin
      for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
      base = $urandom_range(0, 1023);
      wl   = $urandom_range(0, 31);
      load_model(base, wl);
      start_run(base, wl, 1'b0);
      collect(1'b1, 16);
      idle_cycles(1);
    end

    // Ignored start during FETCH, then reset in the middle of EMIT
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
    load_model(300, 6);
    start_run(300, 6, 1'b1);
    collect(1'b1, 5);
    reset = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(posedge clk); #1;
    check_reset_vals("rst_hold");
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("rst_after");

    base = $urandom_range(0, 1023);
    wl   = $urandom_range(1, 31);
    load_model(base, wl);
    start_run(base, wl, 1'b0);
    collect(1'b1, 16);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
